// File: rtl/seg7_pkg.sv
// Shared constants for the product display: active-low segment codes,
// conversion FSM encoding and digit counts.
package seg7_pkg;

  // {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t CONVERT = 2'd1;
  localparam state_t UPDATE  = 2'd2;

  localparam int NUM_DIGITS = 8;
  localparam int BCD_DIGITS = 5;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [4*BCD_DIGITS-1:0] add3_nibbles(input logic [4*BCD_DIGITS-1:0] bcd);
    logic [4*BCD_DIGITS-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Decode one digit; non-BCD codes and blanked positions show nothing.
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/product_display_driver.sv
// Latches a signed product, converts its magnitude to BCD one bit per clock
// and scans sign plus up to five digits onto the 8-digit 7-segment display.
module product_display_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] product,
  input  logic          load,
  output logic          busy,
  output logic [7:0]    an,
  output logic [6:0]    seg,
  output logic          dp
);

  localparam int CW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW  = 4 * BCD_DIGITS;
  localparam int NW  = $clog2(DW) + 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(DW - 1);

  state_t        state_r;
  logic          busy_r;
  logic          sign_r;
  logic [DW-1:0] mag_r;
  logic [BW-1:0] bcd_r;
  logic [NW-1:0] bit_cnt_r;
  logic [BW-1:0] disp_bcd_r;
  logic          disp_sign_r;

  logic [CW-1:0] scan_cnt_r;
  logic [2:0]    scan_idx_r;
  logic [7:0]    an_r;
  logic [6:0]    seg_r;

  logic [BW-1:0] bcd_adj_s;
  logic [2:0]    msd_s;
  logic [3:0]    digit_s;
  logic          blank_s;
  logic          minus_s;
  logic [6:0]    dec_seg_s;

  assign bcd_adj_s = add3_nibbles(bcd_r);

  // Conversion FSM: capture on accepted load, shift DW times, publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      sign_r      <= 1'b0;
      mag_r       <= '0;
      bcd_r       <= '0;
      bit_cnt_r   <= '0;
      disp_bcd_r  <= '0;
      disp_sign_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load) begin
            sign_r    <= product[DW-1];
            mag_r     <= product[DW-1] ? (~product + {{(DW-1){1'b0}}, 1'b1}) : product;
            bcd_r     <= '0;
            bit_cnt_r <= '0;
            busy_r    <= 1'b1;
            state_r   <= CONVERT;
          end else begin
            state_r   <= IDLE;
          end
        end
        CONVERT: begin
          bcd_r     <= {bcd_adj_s[BW-2:0], mag_r[DW-1]};
          mag_r     <= {mag_r[DW-2:0], 1'b0};
          bit_cnt_r <= bit_cnt_r + {{(NW-1){1'b0}}, 1'b1};
          if (bit_cnt_r == BIT_LAST) begin
            state_r <= UPDATE;
          end else begin
            state_r <= CONVERT;
          end
        end
        UPDATE: begin
          disp_bcd_r  <= bcd_r;
          disp_sign_r <= sign_r;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Most significant non-zero digit; digit 0 is always shown.
  always_comb begin
    msd_s = 3'd0;
    if (disp_bcd_r[19:16] != 4'd0) begin
      msd_s = 3'd4;
    end else if (disp_bcd_r[15:12] != 4'd0) begin
      msd_s = 3'd3;
    end else if (disp_bcd_r[11:8] != 4'd0) begin
      msd_s = 3'd2;
    end else if (disp_bcd_r[7:4] != 4'd0) begin
      msd_s = 3'd1;
    end else begin
      msd_s = 3'd0;
    end
  end

  // Digit mux for the currently scanned position.
  always_comb begin
    digit_s = 4'd0;
    blank_s = 1'b1;
    minus_s = 1'b0;
    case (scan_idx_r)
      3'd0:    digit_s = disp_bcd_r[3:0];
      3'd1:    digit_s = disp_bcd_r[7:4];
      3'd2:    digit_s = disp_bcd_r[11:8];
      3'd3:    digit_s = disp_bcd_r[15:12];
      3'd4:    digit_s = disp_bcd_r[19:16];
      default: digit_s = 4'd0;
    endcase
    if (scan_idx_r <= msd_s) begin
      blank_s = 1'b0;
    end else if ((scan_idx_r == msd_s + 3'd1) && disp_sign_r && (disp_bcd_r != '0)) begin
      minus_s = 1'b1;
    end else begin
      blank_s = 1'b1;
    end
  end

  bcd_to_seg7 u_dec (
    .digit (digit_s),
    .blank (blank_s),
    .seg   (dec_seg_s)
  );

  // Scan timing and registered anode/segment drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_r <= '0;
      scan_idx_r <= 3'd0;
      an_r       <= 8'hFF;
      seg_r      <= SEG_BLANK;
    end else begin
      if (scan_cnt_r == SCAN_LAST) begin
        scan_cnt_r <= '0;
        scan_idx_r <= scan_idx_r + 3'd1;
      end else begin
        scan_cnt_r <= scan_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
      an_r  <= ~(8'h01 << scan_idx_r);
      seg_r <= minus_s ? SEG_MINUS : dec_seg_s;
    end
  end

  assign busy = busy_r;
  assign an   = an_r;
  assign seg  = seg_r;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_product_display_driver.sv
// Directed self-checking bench for product_display_driver with SCAN_DIV=4.
module tb_product_display_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] product;
  logic        load;
  logic        busy;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] cap [8];

  product_display_driver #(.SCAN_DIV(4), .DW(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .product (product),
    .load    (load),
    .busy    (busy),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] val);
    product = val;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    product = 16'h5A5A;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_eq("busy_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic capture_and_check(input string tag, input logic [63:0] exp);
    int hot;
    for (int i = 0; i < 8; i++) cap[i] = 8'hEE;
    for (int c = 0; c < 40; c++) begin
      hot = 0;
      for (int i = 0; i < 8; i++) begin
        if (an == ~(8'h01 << i)) begin
          cap[i] = {1'b0, seg};
          hot++;
        end
      end
      check_eq({tag, "_onehot"}, hot, 32'd1);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("%s_d%0d", tag, i), {24'd0, cap[i]}, {24'd0, exp[8*i +: 8]});
    end
  endtask

  initial begin
    int n;
    reset   = 1'b1;
    load    = 1'b0;
    product = 16'h0000;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_an", {24'd0, an}, 32'h0000_00FF);
    check_eq("rst_seg", {25'd0, seg}, 32'h0000_007F);
    check_eq("rst_dp", {31'd0, dp}, 32'd1);
    reset = 1'b0;

    // Scan sequence with value 0 displayed.
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check_eq($sformatf("scan_an_%0d", k), {24'd0, an}, {24'd0, ~(8'h01 << (((k - 1) / 4) % 8))});
      check_eq($sformatf("scan_seg_%0d", k), {25'd0, seg},
               (((k - 1) / 4) % 8 == 0) ? 32'h40 : 32'h7F);
    end

    // -16256 and busy length
    do_load(16'hC080);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_eq("busy_len", n, 32'd17);
    @(negedge clk);
    capture_and_check("neg16256", 64'h7F7F_3F79_0224_1202);

    do_load(16'h4000);
    wait_idle();
    capture_and_check("pos16384", 64'h7F7F_7F79_0230_0019);

    do_load(16'hFFFB);
    wait_idle();
    capture_and_check("neg5", 64'h7F7F_7F7F_7F7F_3F12);

    do_load(16'h0000);
    wait_idle();
    capture_and_check("zero", 64'h7F7F_7F7F_7F7F_7F40);

    // Load while busy must be ignored.
    do_load(16'h0019);
    @(negedge clk);
    @(negedge clk);
    check_eq("busy_mid", {31'd0, busy}, 32'd1);
    do_load(16'h0001);
    wait_idle();
    capture_and_check("ignored", 64'h7F7F_7F7F_7F7F_2412);

    // Reset mid-conversion aborts and clears the display.
    do_load(16'h8000);
    repeat (7) @(negedge clk);
    check_eq("conv_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_an", {24'd0, an}, 32'h0000_00FF);
    reset = 1'b0;
    @(negedge clk);
    capture_and_check("abort", 64'h7F7F_7F7F_7F7F_7F40);

    do_load(16'h8000);
    wait_idle();
    capture_and_check("neg32768", 64'h7F7F_3F30_2478_0200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
